// File: rtl/exe_hazard_forward_ctrl.sv
// rtl/exe_hazard_forward_ctrl.sv - execute-stage forwarding select, load-use stall, flush and freeze control
//
// Keeps a shadow copy of the destination/control fields of the instructions
// held in EX, MEM and WB. From that shadow state it drives the EX operand
// source selects, and from the ID decode fields it decides whether the ID/EX
// boundary advances, takes a stall bubble, takes a flush bubble or freezes.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   id_valid                     ID holds a real instruction
//   id_src1, id_src2             ID source register indices
//   id_use_src1, id_use_src2     ID instruction reads the corresponding source
//   id_dst, id_wb_en             ID destination index and write-back enable
//   id_mem_read                  ID instruction is a load
//   branch_taken                 EX branch resolved taken this cycle
//   mem_freeze                   MEM waiting on memory, whole pipeline holds
//   sel_src1, sel_src2           EX operand selects: 00 reg file, 01 MEM, 10 WB
//   stall                        hold PC and IF/ID, bubble into ID/EX
//   flush                        squash IF/ID and ID/EX (taken branch)
//   freeze                       hold every pipeline register
//   stall_count                  saturating count of stall and freeze cycles

module exe_hazard_forward_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [3:0]       id_dst,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    input  logic             mem_freeze,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             stall,
    output logic             flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_count
);

    // Fields common to every shadow stage.
    typedef struct packed {
        logic       valid;
        logic [3:0] dst;
        logic       wb_en;
        logic       mem_read;
    } stage_t;

    // EX also remembers its own sources so the selects can be formed there.
    typedef struct packed {
        stage_t     base;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use_src1;
        logic       use_src2;
    } ex_stage_t;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    ex_stage_t ex_q;
    stage_t    mem_q;
    stage_t    wb_q;

    ex_stage_t ex_from_id;
    logic      hazard;
    logic      hazard_src1;
    logic      hazard_src2;
    logic      count_en;

    // A stage can only supply (or block) a value if it really writes the
    // register being read and the reader actually uses it.
    function automatic logic match(input stage_t st, input logic [3:0] src, input logic use_src);
        return st.valid & st.wb_en & use_src & (st.dst == src);
    endfunction

    // MEM holds the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_select(input stage_t mem_st, input stage_t wb_st,
                                              input logic [3:0] src, input logic use_src);
        logic [1:0] sel;
        sel = SEL_REG;
        if (match(mem_st, src, use_src)) begin
            sel = SEL_MEM;
        end else if (match(wb_st, src, use_src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Operand selects
    always_comb begin
        sel_src1 = SEL_REG;
        sel_src2 = SEL_REG;
        if (FWD_EN) begin
            sel_src1 = fwd_select(mem_q, wb_q, ex_q.src1, ex_q.use_src1);
            sel_src2 = fwd_select(mem_q, wb_q, ex_q.src2, ex_q.use_src2);
        end
    end

    // RAW hazard detection on the instruction currently in ID.
    // With forwarding only a load in EX is too late to forward from; without
    // forwarding any pending writer in EX or MEM must retire first (WB is
    // assumed to write the register file before ID reads it).
    always_comb begin
        hazard_src1 = 1'b0;
        hazard_src2 = 1'b0;
        if (FWD_EN) begin
            hazard_src1 = ex_q.base.mem_read & match(ex_q.base, id_src1, id_use_src1);
            hazard_src2 = ex_q.base.mem_read & match(ex_q.base, id_src2, id_use_src2);
        end else begin
            hazard_src1 = match(ex_q.base, id_src1, id_use_src1) | match(mem_q, id_src1, id_use_src1);
            hazard_src2 = match(ex_q.base, id_src2, id_use_src2) | match(mem_q, id_src2, id_use_src2);
        end
        hazard = id_valid & (hazard_src1 | hazard_src2);
    end

    // Pipeline control, priority freeze > flush > stall
    always_comb begin
        freeze   = mem_freeze;
        flush    = branch_taken & ~mem_freeze;
        stall    = hazard & ~mem_freeze & ~branch_taken;
        count_en = stall | freeze;
    end

    always_comb begin
        ex_from_id               = '0;
        ex_from_id.base.valid    = id_valid;
        ex_from_id.base.dst      = id_dst;
        ex_from_id.base.wb_en    = id_wb_en;
        ex_from_id.base.mem_read = id_mem_read;
        ex_from_id.src1          = id_src1;
        ex_from_id.src2          = id_src2;
        ex_from_id.use_src1      = id_use_src1;
        ex_from_id.use_src2      = id_use_src2;
    end

    // Shadow stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_freeze) begin
            mem_q <= ex_q.base;
            wb_q  <= mem_q;
            // A flush or stall both put a bubble into EX; the stalled ID
            // instruction is presented again next cycle by the pipeline.
            if (branch_taken || hazard) begin
                ex_q <= '0;
            end else begin
                ex_q <= ex_from_id;
            end
        end
    end

    // Stall/freeze cycle counter, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (count_en && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exe_hazard_forward_ctrl.sv
// tb/tb_exe_hazard_forward_ctrl.sv - self-checking bench for exe_hazard_forward_ctrl

module tb_exe_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src1, id_src2, id_dst;
    logic       id_use_src1, id_use_src2, id_wb_en, id_mem_read;
    logic       branch_taken, mem_freeze;

    logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
    logic        a_stall, a_flush, a_freeze, b_stall, b_flush, b_freeze;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    // Forwarding variant
    exe_hazard_forward_ctrl #(.FWD_EN(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken), .mem_freeze(mem_freeze),
        .sel_src1(a_sel1), .sel_src2(a_sel2),
        .stall(a_stall), .flush(a_flush), .freeze(a_freeze),
        .stall_count(a_cnt)
    );

    // Stall-only variant with a tiny counter to reach saturation
    exe_hazard_forward_ctrl #(.FWD_EN(1'b0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .branch_taken(branch_taken), .mem_freeze(mem_freeze),
        .sel_src1(b_sel1), .sel_src2(b_sel2),
        .stall(b_stall), .flush(b_flush), .freeze(b_freeze),
        .stall_count(b_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       valid;
        bit [3:0] dst;
        bit       wb;
        bit       mr;
        bit [3:0] s1;
        bit [3:0] s2;
        bit       u1;
        bit       u2;
    } rec_t;

    // m[v][k]: variant v, k = distance from EX (0 EX, 1 MEM, 2 WB)
    rec_t m [2][3];
    int   cnt [2];
    int   cmax [2] = '{65535, 7};
    bit   fwd [2]  = '{1'b1, 1'b0};

    function automatic bit mt(rec_t r, bit [3:0] s, bit u);
        return r.valid && r.wb && u && (r.dst == s);
    endfunction

    // The select code equals the distance of the nearest producer ahead of EX.
    function automatic logic [1:0] exp_sel(int v, int n);
        bit [3:0] s;
        bit u;
        if (!fwd[v]) return 2'b00;
        s = (n == 1) ? m[v][0].s1 : m[v][0].s2;
        u = (n == 1) ? m[v][0].u1 : m[v][0].u2;
        for (int k = 1; k <= 2; k++)
            if (mt(m[v][k], s, u)) return 2'(k);
        return 2'b00;
    endfunction

    function automatic bit exp_hz(int v);
        bit [3:0] s;
        bit u;
        if (!id_valid) return 1'b0;
        for (int n = 1; n <= 2; n++) begin
            s = (n == 1) ? id_src1 : id_src2;
            u = (n == 1) ? id_use_src1 : id_use_src2;
            if (fwd[v]) begin
                if (m[v][0].mr && mt(m[v][0], s, u)) return 1'b1;
            end else begin
                for (int k = 0; k <= 1; k++)
                    if (mt(m[v][k], s, u)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                for (int k = 0; k < 3; k++) m[v][k] = '0;
                cnt[v] = 0;
            end
            started = 1'b1;
        end else begin
            for (int v = 0; v < 2; v++) begin
                bit hz;
                rec_t nxt;
                hz = exp_hz(v);
                if (mem_freeze || (hz && !branch_taken))
                    cnt[v] = (cnt[v] < cmax[v]) ? cnt[v] + 1 : cmax[v];
                if (!mem_freeze) begin
                    nxt = '{valid: id_valid, dst: id_dst, wb: id_wb_en, mr: id_mem_read,
                            s1: id_src1, s2: id_src2, u1: id_use_src1, u2: id_use_src2};
                    m[v][2] = m[v][1];
                    m[v][1] = m[v][0];
                    m[v][0] = (branch_taken || hz) ? rec_t'('0) : nxt;
                end
            end
        end
    end

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both variants against the model
    always @(negedge clk) begin
        if (started) begin
            for (int v = 0; v < 2; v++) begin
                bit hz;
                hz = exp_hz(v);
                check($sformatf("v%0d_sel1", v), v ? b_sel1 : a_sel1, exp_sel(v, 1));
                check($sformatf("v%0d_sel2", v), v ? b_sel2 : a_sel2, exp_sel(v, 2));
                check($sformatf("v%0d_freeze", v), v ? b_freeze : a_freeze, mem_freeze);
                check($sformatf("v%0d_flush", v), v ? b_flush : a_flush, branch_taken && !mem_freeze);
                check($sformatf("v%0d_stall", v), v ? b_stall : a_stall, hz && !mem_freeze && !branch_taken);
                check($sformatf("v%0d_count", v), v ? int'(b_cnt) : int'(a_cnt), cnt[v]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic to_pos;
        @(posedge clk); #1;
    endtask

    task automatic to_neg;
        @(negedge clk); #1;
    endtask

    task automatic id_in(bit v, bit [3:0] d, bit wb, bit mr,
                         bit [3:0] s1, bit u1, bit [3:0] s2, bit u2);
        id_valid = v; id_dst = d; id_wb_en = wb; id_mem_read = mr;
        id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
    endtask

    task automatic nop;
        id_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset;
        to_pos;
        rst = 1'b1; mem_freeze = 1'b0; branch_taken = 1'b0; nop;
        to_pos;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b0; mem_freeze = 1'b0; nop;
        to_pos; to_pos;
        rst = 1'b0;
        to_neg;
        check("rst_sel1", a_sel1, 0);
        check("rst_sel2", a_sel2, 0);
        check("rst_stall", a_stall, 0);
        check("rst_flush", a_flush, 0);
        check("rst_freeze", a_freeze, 0);
        check("rst_count", a_cnt, 0);

        // back-to-back ALU dependency
        to_pos; id_in(1, 3, 1, 0, 0, 0, 0, 0);
        to_pos; id_in(1, 7, 1, 0, 3, 1, 0, 0);
        to_neg; check("alu_no_stall", a_stall, 0);
        to_pos; id_in(1, 8, 1, 0, 0, 0, 3, 1);
        to_neg; check("alu_sel1_mem", a_sel1, 2'b01);
        check("alu_no_stall2", a_stall, 0);
        to_pos; nop;
        to_neg; check("alu_sel2_wb", a_sel2, 2'b10);

        // load-use
        do_reset;
        to_neg; check("lu_cnt0", a_cnt, 0);
        id_in(1, 5, 1, 1, 0, 0, 0, 0);
        to_pos; id_in(1, 9, 1, 0, 0, 0, 5, 1);
        to_neg; check("lu_stall", a_stall, 1);
        to_pos;
        to_neg; check("lu_release", a_stall, 0);
        check("lu_cnt1", a_cnt, 1);
        to_pos; nop;
        to_neg; check("lu_sel2_wb", a_sel2, 2'b10);

        // double producer
        do_reset;
        id_in(1, 2, 1, 0, 0, 0, 0, 0);
        to_pos; id_in(1, 2, 1, 0, 0, 0, 0, 0);
        to_pos; id_in(1, 4, 1, 0, 2, 1, 0, 0);
        to_pos; nop;
        to_neg; check("dbl_mem_wins", a_sel1, 2'b01);

        // branch with pending load-use
        do_reset;
        id_in(1, 5, 1, 1, 0, 0, 0, 0);
        to_pos; id_in(1, 9, 1, 0, 5, 1, 0, 0); branch_taken = 1'b1;
        to_neg; check("br_flush", a_flush, 1);
        check("br_no_stall", a_stall, 0);
        to_pos; nop; branch_taken = 1'b0;
        to_neg; check("br_sel1", a_sel1, 0);
        check("br_sel2", a_sel2, 0);
        check("br_cnt", a_cnt, 0);

        // freeze during forwarding, then reset under freeze
        do_reset;
        id_in(1, 3, 1, 0, 0, 0, 0, 0);
        to_pos; id_in(1, 7, 1, 0, 3, 1, 0, 0);
        to_pos; id_in(1, 8, 1, 0, 0, 0, 3, 1); mem_freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            to_neg;
            check("fz_sel1", a_sel1, 2'b01);
            check("fz_freeze", a_freeze, 1);
            check("fz_stall", a_stall, 0);
            to_pos;
        end
        mem_freeze = 1'b0;
        to_neg; check("fz_cnt3", a_cnt, 3);
        check("fz_resume_sel1", a_sel1, 2'b01);
        to_pos; nop;
        to_neg; check("fz_resume_sel2", a_sel2, 2'b10);
        to_pos; mem_freeze = 1'b1; branch_taken = 1'b1;
        to_neg; check("fz_br_noflush", a_flush, 0);
        to_pos; rst = 1'b1; branch_taken = 1'b0;
        to_pos; rst = 1'b0; mem_freeze = 1'b0;
        to_neg; check("fzrst_sel1", a_sel1, 0);
        check("fzrst_freeze", a_freeze, 0);
        check("fzrst_stall", a_stall, 0);
        check("fzrst_cnt", a_cnt, 0);

        // stall-only variant
        do_reset;
        id_in(1, 1, 1, 0, 0, 0, 0, 0);
        to_pos; id_in(1, 6, 1, 0, 1, 1, 0, 0);
        to_neg; check("nf_stall1", b_stall, 1);
        to_pos;
        to_neg; check("nf_stall2", b_stall, 1);
        to_pos;
        to_neg; check("nf_release", b_stall, 0);
        check("nf_cnt2", b_cnt, 2);
        check("nf_sel1", b_sel1, 0);
        to_pos; id_in(1, 1, 1, 0, 0, 0, 0, 0);
        to_pos; id_in(1, 6, 1, 0, 1, 0, 0, 0);
        to_neg; check("nf_unused_src", b_stall, 0);

        // counter saturation on the 3-bit variant
        to_pos; nop; mem_freeze = 1'b1;
        repeat (10) to_pos;
        mem_freeze = 1'b0;
        to_neg; check("nf_sat", b_cnt, 7);

        to_pos;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
